// File: rtl/cpu_clock_controller.sv
// CPU clock-enable sequencer: free-run at a programmable prescale, halt, or
// single-step from a pushbutton, honouring CPU-requested halts.
module cpu_clock_controller #(
    parameter int                   CNT_WIDTH        = 32,
    parameter logic [CNT_WIDTH-1:0] DEFAULT_PRESCALE = CNT_WIDTH'(4_999_999),
    parameter int                   TICK_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run_req,
    input  logic                  step_req,
    input  logic [CNT_WIDTH-1:0]  prescale_in,
    input  logic                  prescale_load,
    input  logic                  cpu_halt,
    output logic                  clk_cpu,
    output logic                  running,
    output logic                  halted,
    output logic [TICK_WIDTH-1:0] tick_count
);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [CNT_WIDTH-1:0]    w_cnt_next;
    logic [CNT_WIDTH-1:0]    r_prescale;
    logic                    r_run_meta;
    logic                    r_run_sync;
    logic                    r_step_meta;
    logic                    r_step_sync;
    logic                    r_step_prev;
    logic                    r_clk_cpu;
    logic                    r_running;
    logic                    r_halted;
    logic [TICK_WIDTH-1:0]   r_tick;
    logic                    w_pulse;
    logic                    w_step_edge;

    assign w_step_edge = r_step_sync & ~r_step_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run_meta  <= 1'b0;
            r_run_sync  <= 1'b0;
            r_step_meta <= 1'b0;
            r_step_sync <= 1'b0;
            r_step_prev <= 1'b0;
        end else begin
            r_run_meta  <= run_req;
            r_run_sync  <= r_run_meta;
            r_step_meta <= step_req;
            r_step_sync <= r_step_meta;
            r_step_prev <= r_step_sync;
        end
    end

    // Exit and prescale reload both beat the terminal count, so neither emits a pulse.
    always_comb begin
        w_next     = r_state;
        w_pulse    = 1'b0;
        w_cnt_next = '0;
        case (r_state)
            S_HALT: begin
                if (r_run_sync && !r_halted) begin
                    w_next = S_RUN;
                end else if (w_step_edge) begin
                    w_next = S_STEP;
                end
            end
            S_RUN: begin
                if (!r_run_sync || cpu_halt) begin
                    w_next = S_HALT;
                end else if (prescale_load) begin
                    w_cnt_next = '0;
                end else if (r_cnt == r_prescale) begin
                    w_pulse    = 1'b1;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_STEP: begin
                w_pulse = 1'b1;
                w_next  = S_HALT;
            end
            default: begin
                w_next = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_HALT;
            r_cnt      <= '0;
            r_prescale <= DEFAULT_PRESCALE;
            r_clk_cpu  <= 1'b0;
            r_running  <= 1'b0;
            r_halted   <= 1'b0;
            r_tick     <= '0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            r_clk_cpu <= w_pulse;
            r_running <= (w_next == S_RUN);
            if (prescale_load) begin
                r_prescale <= prescale_in;
            end
            // Dropping the run switch is the only way to release a CPU halt.
            if (!r_run_sync) begin
                r_halted <= 1'b0;
            end else if (cpu_halt && (r_state == S_RUN)) begin
                r_halted <= 1'b1;
            end
            if (r_clk_cpu) begin
                r_tick <= r_tick + 1'b1;
            end
        end
    end

    assign clk_cpu    = r_clk_cpu;
    assign running    = r_running;
    assign halted     = r_halted;
    assign tick_count = r_tick;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Bench for cpu_clock_controller: directed stimulus pushes expected pulse
// cycles and status snapshots; a negedge monitor pops and compares them.
module tb_cpu_clock_controller;

    localparam int CW = 32;
    localparam int TW = 16;

    logic          clk           = 1'b0;
    logic          reset         = 1'b1;
    logic          run_req       = 1'b0;
    logic          step_req      = 1'b0;
    logic [CW-1:0] prescale_in   = '0;
    logic          prescale_load = 1'b0;
    logic          cpu_halt      = 1'b0;
    logic          clk_cpu;
    logic          running;
    logic          halted;
    logic [TW-1:0] tick_count;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    bit done     = 1'b0;

    typedef struct {
        int          cyc;
        logic [TW-1:0] tick;
    } pulse_t;

    typedef struct {
        int          cyc;
        logic        clk_cpu;
        logic        running;
        logic        halted;
        logic [TW-1:0] tick;
    } stat_t;

    pulse_t pq[$];
    stat_t  sq[$];

    cpu_clock_controller #(
        .CNT_WIDTH       (CW),
        .DEFAULT_PRESCALE(32'd6),
        .TICK_WIDTH      (TW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run_req      (run_req),
        .step_req     (step_req),
        .prescale_in  (prescale_in),
        .prescale_load(prescale_load),
        .cpu_halt     (cpu_halt),
        .clk_cpu      (clk_cpu),
        .running      (running),
        .halted       (halted),
        .tick_count   (tick_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_pulse(input int c, input int t);
        pulse_t p;
        p.cyc  = c;
        p.tick = TW'(t);
        pq.push_back(p);
    endtask

    task automatic push_stat(input int c, input logic ck, input logic rn, input logic hl, input int t);
        stat_t s;
        s.cyc     = c;
        s.clk_cpu = ck;
        s.running = rn;
        s.halted  = hl;
        s.tick    = TW'(t);
        sq.push_back(s);
    endtask

    // Stimulus: cycle numbers below are the tb cycle counter value after each posedge.
    initial begin
        wait_to(3);
        push_stat(3, 1'b0, 1'b0, 1'b0, 0);
        wait_to(4);
        reset = 1'b0;

        // prescale 3 then run: RUN entered at 10, pulses every 4 from 14
        wait_to(6);
        prescale_in   = 32'd3;
        prescale_load = 1'b1;
        for (int i = 0; i < 5; i++) push_pulse(14 + 4 * i, i);
        push_stat(12, 1'b0, 1'b1, 1'b0, 0);
        push_stat(31, 1'b0, 1'b1, 1'b0, 5);
        wait_to(7);
        prescale_load = 1'b0;
        run_req       = 1'b1;

        // prescale 0 in RUN: pulse every cycle until the synced run drop
        wait_to(31);
        prescale_in   = 32'd0;
        prescale_load = 1'b1;
        for (int i = 0; i < 7; i++) push_pulse(33 + i, 5 + i);
        push_stat(40, 1'b0, 1'b0, 1'b0, 12);
        wait_to(32);
        prescale_load = 1'b0;
        wait_to(37);
        run_req = 1'b0;

        // single step: a long press gives one pulse, second press one more
        wait_to(43);
        step_req = 1'b1;
        push_pulse(47, 12);
        push_pulse(107, 13);
        push_stat(48, 1'b0, 1'b0, 1'b0, 13);
        push_stat(120, 1'b0, 1'b0, 1'b0, 14);
        wait_to(93);
        step_req = 1'b0;
        wait_to(103);
        step_req = 1'b1;
        wait_to(113);
        step_req = 1'b0;

        // prescale 9, step press ignored in RUN, cpu_halt at cnt 5, resume
        wait_to(123);
        prescale_in   = 32'd9;
        prescale_load = 1'b1;
        push_pulse(137, 14);
        push_stat(143, 1'b0, 1'b0, 1'b1, 15);
        push_stat(164, 1'b0, 1'b0, 1'b1, 15);
        push_stat(168, 1'b0, 1'b0, 1'b0, 15);
        push_stat(172, 1'b0, 1'b1, 1'b0, 15);
        wait_to(124);
        prescale_load = 1'b0;
        run_req       = 1'b1;
        wait_to(128);
        step_req = 1'b1;
        wait_to(132);
        step_req = 1'b0;
        wait_to(142);
        cpu_halt = 1'b1;
        wait_to(143);
        cpu_halt = 1'b0;
        wait_to(164);
        run_req = 1'b0;
        wait_to(169);
        run_req = 1'b1;

        // reload to 2 at cnt 7, then a reload on the terminal-count cycle
        wait_to(170);
        push_pulse(183, 15);
        push_pulse(186, 16);
        push_pulse(189, 17);
        push_pulse(195, 18);
        push_stat(197, 1'b0, 1'b0, 1'b0, 0);
        push_stat(198, 1'b0, 1'b0, 1'b0, 0);
        push_stat(204, 1'b0, 1'b1, 1'b0, 0);
        push_pulse(209, 0);
        push_pulse(216, 1);
        wait_to(179);
        prescale_in   = 32'd2;
        prescale_load = 1'b1;
        wait_to(180);
        prescale_load = 1'b0;
        wait_to(191);
        prescale_load = 1'b1;
        wait_to(192);
        prescale_load = 1'b0;

        // reset one cycle before a due pulse; default prescale (6) returns
        wait_to(197);
        reset = 1'b1;
        wait_to(199);
        reset = 1'b0;

        // tick counter wrap: 65534 more pulses at prescale 0 bring it to 0
        wait_to(217);
        prescale_in   = 32'd0;
        prescale_load = 1'b1;
        for (int i = 0; i < 65534; i++) push_pulse(219 + i, 2 + i);
        push_stat(65755, 1'b0, 1'b0, 1'b0, 0);
        wait_to(218);
        prescale_load = 1'b0;
        wait_to(65750);
        run_req = 1'b0;
        wait_to(65760);
        done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        pulse_t p;
        stat_t  s;
        forever begin
            @(negedge clk);
            while (pq.size() > 0 && pq[0].cyc < cyc) begin
                p = pq.pop_front();
                checks++;
                failures++;
                $display("FAIL pulse_missing at cyc=%0d: no clk_cpu pulse, required one at cyc=%0d", cyc, p.cyc);
            end
            if (clk_cpu !== 1'b0) begin
                checks++;
                if (pq.size() == 0 || pq[0].cyc != cyc) begin
                    failures++;
                    $display("FAIL pulse_unexpected at cyc=%0d: clk_cpu=%b, required 0", cyc, clk_cpu);
                end else begin
                    p = pq.pop_front();
                    checks++;
                    if (tick_count !== p.tick) begin
                        failures++;
                        $display("FAIL pulse_tick at cyc=%0d: tick_count=%0d, required %0d", cyc, tick_count, p.tick);
                    end
                end
            end
            while (sq.size() > 0 && sq[0].cyc <= cyc) begin
                s = sq.pop_front();
                checks++;
                if (s.cyc != cyc) begin
                    failures++;
                    $display("FAIL status_skipped at cyc=%0d: snapshot for cyc=%0d not taken", cyc, s.cyc);
                end else if (clk_cpu !== s.clk_cpu || running !== s.running ||
                             halted !== s.halted || tick_count !== s.tick) begin
                    failures++;
                    $display("FAIL status at cyc=%0d: clk_cpu=%b running=%b halted=%b tick=%0d, required %b %b %b %0d",
                             cyc, clk_cpu, running, halted, tick_count,
                             s.clk_cpu, s.running, s.halted, s.tick);
                end
            end
            if (done) begin
                checks++;
                if (pq.size() != 0 || sq.size() != 0) begin
                    failures++;
                    $display("FAIL queues_drained: pulses_left=%0d status_left=%0d, required 0 0", pq.size(), sq.size());
                end
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not complete by cyc=%0d, required completion by 65760", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
